// File: rtl/if_resp_buffer.sv
// Fetch response buffer: pairs in-order instruction-SRAM responses with the PCs
// of accepted requests and queues {pc, inst, adef} for the decode stage.
module if_resp_buffer #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_fire,
    input  logic [31:0] req_pc,
    input  logic        req_adef,
    input  logic        data_ok,
    input  logic [31:0] rdata,
    input  logic        flush,
    input  logic        id_allowin,
    output logic        can_issue,
    output logic        out_valid,
    output logic [64:0] out_data,
    output logic        proto_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int SW = CW + 1;
    localparam logic [AW-1:0] ONE_A   = AW'(1);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] ZERO_C  = CW'(0);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   pend_pc_r   [DEPTH];
    logic          pend_adef_r [DEPTH];
    logic [AW-1:0] pend_wr_r;
    logic [AW-1:0] pend_rd_r;
    logic [CW-1:0] pend_cnt_r;
    logic [64:0]   res_data_r  [DEPTH];
    logic [AW-1:0] res_wr_r;
    logic [AW-1:0] res_rd_r;
    logic [CW-1:0] res_cnt_r;
    logic [CW-1:0] discard_cnt_r;
    logic          flush_d_r;
    logic          proto_err_r;

    logic          pend_push_s;
    logic          pend_pop_s;
    logic          res_push_s;
    logic          res_pop_s;
    logic          out_valid_s;
    logic [CW-1:0] pend_cnt_nxt_s;
    logic [CW-1:0] res_cnt_nxt_s;
    logic [CW-1:0] discard_nxt_s;
    logic [SW-1:0] disc_sum_s;
    logic [SW-1:0] disc_raw_s;
    logic [CW-1:0] disc_limit_s;
    logic          proto_err_nxt_s;
    logic [SW-1:0] occupancy_s;

    // handshake decode, counter next-state and discard accounting
    always_comb begin
        pend_push_s     = req_fire & (pend_cnt_r != DEPTH_C);
        pend_pop_s      = data_ok & (pend_cnt_r != ZERO_C);
        out_valid_s     = (res_cnt_r != ZERO_C) & ~flush & ~flush_d_r;
        res_pop_s       = out_valid_s & id_allowin;
        res_push_s      = pend_pop_s & (discard_cnt_r == ZERO_C) & ~flush &
                          ((res_cnt_r != DEPTH_C) | res_pop_s);
        pend_cnt_nxt_s  = pend_cnt_r + (pend_push_s ? ONE_C : ZERO_C)
                                     - (pend_pop_s  ? ONE_C : ZERO_C);
        disc_sum_s      = {1'b0, discard_cnt_r} + {1'b0, pend_cnt_r};
        disc_raw_s      = disc_sum_s;
        disc_limit_s    = pend_cnt_r - (pend_pop_s ? ONE_C : ZERO_C);
        discard_nxt_s   = discard_cnt_r;
        res_cnt_nxt_s   = res_cnt_r;
        proto_err_nxt_s = proto_err_r | (data_ok & (pend_cnt_r == ZERO_C)) |
                          (req_fire & (pend_cnt_r == DEPTH_C));
        occupancy_s     = {1'b0, pend_cnt_r} + {1'b0, res_cnt_r};

        // a redirect turns every request accepted before this cycle into a discard
        if (flush) begin
            if (data_ok && (disc_sum_s != SW'(0))) begin
                disc_raw_s = disc_sum_s - SW'(1);
            end else begin
                disc_raw_s = disc_sum_s;
            end
            if (disc_raw_s > {1'b0, disc_limit_s}) begin
                discard_nxt_s = disc_limit_s;
            end else begin
                discard_nxt_s = disc_raw_s[CW-1:0];
            end
            res_cnt_nxt_s = ZERO_C;
        end else begin
            if (pend_pop_s && (discard_cnt_r != ZERO_C)) begin
                discard_nxt_s = discard_cnt_r - ONE_C;
            end else begin
                discard_nxt_s = discard_cnt_r;
            end
            res_cnt_nxt_s = res_cnt_r + (res_push_s ? ONE_C : ZERO_C)
                                      - (res_pop_s  ? ONE_C : ZERO_C);
        end
    end

    assign can_issue = occupancy_s < {1'b0, DEPTH_C};
    assign out_valid = out_valid_s;
    assign out_data  = res_data_r[res_rd_r];
    assign proto_err = proto_err_r;

    // pending PC FIFO storage and pointers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pend_pc_r[i]   <= 32'h0;
                pend_adef_r[i] <= 1'b0;
            end
            pend_wr_r <= '0;
            pend_rd_r <= '0;
        end else begin
            if (pend_push_s) begin
                pend_pc_r[pend_wr_r]   <= req_pc;
                pend_adef_r[pend_wr_r] <= req_adef;
                pend_wr_r              <= pend_wr_r + ONE_A;
            end
            if (pend_pop_s) begin
                pend_rd_r <= pend_rd_r + ONE_A;
            end
        end
    end

    // result queue storage and pointers; a redirect empties it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                res_data_r[i] <= 65'h0;
            end
            res_wr_r <= '0;
            res_rd_r <= '0;
        end else if (flush) begin
            res_wr_r <= '0;
            res_rd_r <= '0;
        end else begin
            if (res_push_s) begin
                res_data_r[res_wr_r] <= {pend_pc_r[pend_rd_r], rdata, pend_adef_r[pend_rd_r]};
                res_wr_r             <= res_wr_r + ONE_A;
            end
            if (res_pop_s) begin
                res_rd_r <= res_rd_r + ONE_A;
            end
        end
    end

    // occupancy counters, discard count and sticky status
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_cnt_r    <= ZERO_C;
            res_cnt_r     <= ZERO_C;
            discard_cnt_r <= ZERO_C;
            flush_d_r     <= 1'b0;
            proto_err_r   <= 1'b0;
        end else begin
            pend_cnt_r    <= pend_cnt_nxt_s;
            res_cnt_r     <= res_cnt_nxt_s;
            discard_cnt_r <= discard_nxt_s;
            flush_d_r     <= flush;
            proto_err_r   <= proto_err_nxt_s;
        end
    end

endmodule

// File: tb/tb_if_resp_buffer.sv
// Scoreboard bench for if_resp_buffer: directed fetch traffic, expected
// instructions queued at response time and checked when ID takes them.
module tb_if_resp_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_fire;
    logic [31:0] req_pc;
    logic        req_adef;
    logic        data_ok;
    logic [31:0] rdata;
    logic        flush;
    logic        id_allowin;
    logic        can_issue;
    logic        out_valid;
    logic [64:0] out_data;
    logic        proto_err;

    logic [64:0] sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    if_resp_buffer #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset), .req_fire(req_fire), .req_pc(req_pc),
        .req_adef(req_adef), .data_ok(data_ok), .rdata(rdata), .flush(flush),
        .id_allowin(id_allowin), .can_issue(can_issue), .out_valid(out_valid),
        .out_data(out_data), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // one clock: inputs set beforehand take effect at the edge, then pulses clear
    task automatic step();
        @(posedge clk);
        #1;
        req_fire = 1'b0;
        req_adef = 1'b0;
        data_ok  = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic req(input logic [31:0] pc, input logic adef);
        req_fire = 1'b1;
        req_pc   = pc;
        req_adef = adef;
    endtask

    task automatic resp(input logic [31:0] w, input logic [31:0] pc, input logic adef, input bit keep);
        data_ok = 1'b1;
        rdata   = w;
        if (keep) sb.push_back({pc, w, adef});
    endtask

    // monitor: whatever ID takes must match the head of the scoreboard
    always @(negedge clk) begin
        if (reset && out_valid && id_allowin) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", out_data, 65'h0);
            end else begin
                chk("sb_out", out_data, sb.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b0; req_fire = 1'b0; req_pc = 32'h0; req_adef = 1'b0;
        data_ok = 1'b0; rdata = 32'h0; flush = 1'b0; id_allowin = 1'b1;
        step(); step();
        chk("rst_out_valid", 65'(out_valid), 65'h0);
        chk("rst_can_issue", 65'(can_issue), 65'h1);
        chk("rst_proto_err", 65'(proto_err), 65'h0);
        chk("rst_out_data", out_data, 65'h0);
        reset = 1'b1;
        step();

        // single fetch, answered two cycles later
        req(32'h1C000000, 1'b0); step();
        step();
        resp(32'h02800C0C, 32'h1C000000, 1'b0, 1'b1); step();
        chk("t1_out_valid", 65'(out_valid), 65'h1);
        chk("t1_out_data", out_data, {32'h1C000000, 32'h02800C0C, 1'b0});
        step();
        chk("t1_popped", 65'(out_valid), 65'h0);
        chk("t1_can_issue", 65'(can_issue), 65'h1);

        // fill the buffer with ID stalled, then drain in order
        id_allowin = 1'b0;
        req(32'h1C000000, 1'b0); step();
        req(32'h1C000004, 1'b0); resp(32'h11111111, 32'h1C000000, 1'b0, 1'b1); step();
        req(32'h1C000008, 1'b0); resp(32'h22222222, 32'h1C000004, 1'b0, 1'b1); step();
        req(32'h1C00000C, 1'b0); resp(32'h33333333, 32'h1C000008, 1'b0, 1'b1); step();
        chk("t2_can_issue_full", 65'(can_issue), 65'h0);
        resp(32'h44444444, 32'h1C00000C, 1'b0, 1'b1); step();
        chk("t2_can_issue_res", 65'(can_issue), 65'h0);
        chk("t2_valid_held", 65'(out_valid), 65'h1);
        chk("t2_head", out_data, {32'h1C000000, 32'h11111111, 1'b0});
        id_allowin = 1'b1;
        step(); step(); step(); step();
        chk("t2_drained", 65'(out_valid), 65'h0);
        chk("t2_can_issue_back", 65'(can_issue), 65'h1);

        // redirect with two requests in flight; only the target survives
        req(32'h1C000000, 1'b0); step();
        req(32'h1C000004, 1'b0); step();
        req(32'h1C008000, 1'b0); flush = 1'b1; step();
        resp(32'hAAAA0000, 32'h0, 1'b0, 1'b0); step();
        resp(32'hBBBB0000, 32'h0, 1'b0, 1'b0); step();
        chk("t3_nothing_yet", 65'(out_valid), 65'h0);
        resp(32'hCCCC0000, 32'h1C008000, 1'b0, 1'b1); step();
        chk("t3_target", out_data, {32'h1C008000, 32'hCCCC0000, 1'b0});
        step();

        // flush hides a buffered result during the flush cycle and drops it
        id_allowin = 1'b0;
        req(32'h1C000100, 1'b0); step();
        resp(32'h5A5A5A5A, 32'h0, 1'b0, 1'b0); step();
        chk("t4_buffered", 65'(out_valid), 65'h1);
        flush = 1'b1;
        #1;
        chk("t4_flush_cycle", 65'(out_valid), 65'h0);
        step();
        chk("t4_emptied", 65'(out_valid), 65'h0);
        id_allowin = 1'b1;

        // flush together with the only pending response
        req(32'h1C000010, 1'b0); step();
        resp(32'hDEAD0001, 32'h0, 1'b0, 1'b0); flush = 1'b1; step();
        chk("t4_discarded", 65'(out_valid), 65'h0);
        step();
        chk("t4_still_empty", 65'(out_valid), 65'h0);
        chk("t4_can_issue", 65'(can_issue), 65'h1);
        req(32'h1C000020, 1'b0); step();
        resp(32'h33333333, 32'h1C000020, 1'b0, 1'b1); step();
        chk("t4_no_stale_discard", 65'(out_valid), 65'h1);
        step();

        // stray response sets sticky error; traffic (incl. adef) still flows
        resp(32'h0BAD0BAD, 32'h0, 1'b0, 1'b0); step();
        chk("t5_proto_err", 65'(proto_err), 65'h1);
        chk("t5_no_output", 65'(out_valid), 65'h0);
        req(32'h1C000042, 1'b1); step();
        resp(32'h55555555, 32'h1C000042, 1'b1, 1'b1); step();
        chk("t5_adef_entry", out_data, {32'h1C000042, 32'h55555555, 1'b1});
        step();
        chk("t5_proto_sticky", 65'(proto_err), 65'h1);

        // asynchronous reset with work in flight
        id_allowin = 1'b0;
        req(32'h1C000200, 1'b0); step();
        req(32'h1C000204, 1'b0); resp(32'h66666666, 32'h1C000200, 1'b0, 1'b1); step();
        req(32'h1C000208, 1'b0); step();
        chk("t6_pre_valid", 65'(out_valid), 65'h1);
        #2;
        reset = 1'b0;
        sb.delete();
        #1;
        chk("t6_async_valid", 65'(out_valid), 65'h0);
        chk("t6_async_data", out_data, 65'h0);
        chk("t6_async_proto", 65'(proto_err), 65'h0);
        step();
        reset = 1'b1;
        id_allowin = 1'b1;
        chk("t6_can_issue", 65'(can_issue), 65'h1);
        resp(32'h77777777, 32'h0, 1'b0, 1'b0); step();
        chk("t6_late_resp_err", 65'(proto_err), 65'h1);
        chk("t6_late_resp_out", 65'(out_valid), 65'h0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        chk("sb_drained", 65'(sb.size()), 65'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_resp_buffer.md
Name: if_resp_buffer

Overview:
- Sits between the fetch request stage and the ID stage.
- Records the PC of every instruction-SRAM request accepted (addr_ok handshake) and pairs it with the in-order data_ok response.
- Buffers up to DEPTH fetched instructions and presents {pc, inst, adef} to ID with a valid/allowin handshake.
- On a redirect (branch, exception entry or exception return) it drops queued instructions and discards responses to requests issued before the redirect.

Parameters:
- DEPTH, 2, maximum outstanding requests plus buffered instructions (power of two, 2..8).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req_fire  in  1  fetch request accepted this cycle (req & addr_ok).
- req_pc  in  32  PC of the accepted request.
- req_adef  in  1  request PC misaligned (pc[1:0]!=0).
- data_ok  in  1  instruction response valid this cycle; responses arrive in request order.
- rdata  in  32  instruction word, valid with data_ok.
- flush  in  1  redirect this cycle (br_taken | Exception | quit_Exception).
- id_allowin  in  1  ID accepts out_data this cycle.
- can_issue  out  1  fetch may issue a new request this cycle.
- out_valid  out  1  out_data holds a valid instruction.
- out_data  out  65  {pc[31:0], inst[31:0], adef}.
- proto_err  out  1  sticky: data_ok received with no outstanding request.

Behaviour:
- Reset (reset==0, any time, asynchronous): all counters, pointers and discard_cnt cleared; out_valid=0; can_issue=1; proto_err=0; out_data=0. Reset mid-operation aborts all pending pairing, and later responses count as protocol errors.
- Pending queue (PC FIFO, DEPTH entries): push {req_pc, req_adef} on req_fire; pop on data_ok. pend_cnt ranges 0..DEPTH.
- Result queue (DEPTH entries): each non-discarded data_ok pushes {popped pc, rdata, popped adef}. res_cnt ranges 0..DEPTH.
- Response pairing:
  - data_ok with discard_cnt>0: entry popped, nothing pushed, discard_cnt decremented.
  - data_ok with pend_cnt==0: ignored; proto_err set to 1 and held until reset.
- Output:
  - out_valid = (res_cnt!=0) & ~flush_d.
  - out_data = result-queue head, combinational from the registered queue.
  - Pop when out_valid & id_allowin.
  - Push and pop in the same cycle leave res_cnt unchanged.
- Latency: a data_ok in cycle N into an empty result queue gives out_valid=1 in cycle N+1 with that instruction.
- Issue control: can_issue = (pend_cnt + res_cnt) < DEPTH. This guarantees a result slot for every outstanding request, so the result queue never overflows. can_issue is combinational from registers only.
- Flush in cycle N:
  - Result queue emptied at edge N.
  - discard_cnt_next = discard_cnt + pend_cnt − (data_ok ? 1 : 0), clipped at pend_cnt_next − (req_fire ? 1 : 0).
  - Every request accepted before cycle N is discarded. A req_fire in cycle N carries the redirect target and is kept.
  - data_ok in cycle N is discarded and produces no result.
  - out_valid forced 0 in cycle N.
  - flush_d is the registered flush; no extra bubble is required beyond cycle N.
- Back-to-back flushes accumulate discards correctly. discard_cnt never exceeds pend_cnt.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Full and empty are distinguished by the counts, not the pointers.
- Simultaneous req_fire + data_ok with pend_cnt==DEPTH: cannot occur when fetch honours can_issue. If it does occur, the push is dropped and proto_err is set.
- adef entries pass through with adef=1; inst is whatever rdata was returned.

Test Plan:
- Reset, then req_fire pc=0x1C000000, then data_ok rdata=0x02800C0C two cycles later, id_allowin=1 → out_valid one cycle after data_ok, out_data={0x1C000000,0x02800C0C,0}; can_issue back to 1 after the pop.
- id_allowin=0; issue pc 0x1C000000 and 0x1C000004, both answered → can_issue=0, res_cnt=2; raise id_allowin → both delivered in order over 2 cycles.
- Issue pc 0x1C000000 and 0x1C000004; flush together with req_fire pc=0x1C008000; then three data_ok (0xAAAA0000, 0xBBBB0000, 0xCCCC0000) → only {0x1C008000,0xCCCC0000,0} reaches ID.
- Flush in the same cycle as data_ok of the only pending request → response discarded, discard_cnt=0, out_valid stays 0.
- data_ok with nothing pending → proto_err=1 and stays 1; subsequent normal traffic still delivered correctly.
- reset driven low mid-transfer with 2 pending → all outputs 0 immediately (asynchronously); can_issue=1 once reset is released.
